// File: rtl/kuz_key_expand.sv
// Kuznyechik key schedule: 256-bit master key -> round keys K1..K10, RPC Feistel iterations/clock.
// Optional macro KUZ_CONST_ROM_EN selects a precomputed C_i table over on-the-fly L(Vec128(i)).
module kuz_key_expand #(
  parameter int unsigned RPC = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [255:0]  key,
  output logic          busy,
  output logic          done,
  output logic          key_valid,
  input  logic [3:0]    rk_idx,
  output logic [127:0]  rk_out,
  output logic [1279:0] rk_all
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
    $error("kuz_key_expand: RPC must be 1, 2, 4 or 8");
  end

  localparam logic [0:255][7:0] PI = {
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // Coefficient for byte a15 (most significant) first.
  localparam logic [0:15][7:0] LC = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] s_fn(input logic [127:0] x);
    logic [127:0] y;
    for (int b = 0; b < 16; b++) y[8*b +: 8] = PI[x[8*b +: 8]];
    return y;
  endfunction

  function automatic logic [127:0] l_fn(input logic [127:0] x);
    logic [127:0] v;
    logic [7:0]   t;
    v = x;
    for (int r = 0; r < 16; r++) begin
      t = '0;
      for (int b = 0; b < 16; b++) t = t ^ gf_mul(v[8*(15-b) +: 8], LC[b]);
      v = {t, v[127:8]};
    end
    return v;
  endfunction

  typedef enum logic {StIdle, StRun} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [127:0]   a1_q, a1_d, a0_q, a0_d;
  logic [127:0]   rk_q [10];
  logic [127:0]   rk_d [10];
  logic           done_q, done_d, kv_q, kv_d;

  logic [127:0]   ch1 [RPC+1];
  logic [127:0]   ch0 [RPC+1];
  logic [127:0]   cst [RPC];

`ifdef KUZ_CONST_ROM_EN
  logic [127:0] c_rom [32];
  for (genvar g = 0; g < 32; g++) begin : g_rom
    assign c_rom[g] = l_fn({120'd0, 8'(g + 1)});
  end
`endif

  assign ch1[0] = a1_q;
  assign ch0[0] = a0_q;

  for (genvar g = 0; g < RPC; g++) begin : g_iter
    // Iteration number is cnt_q + g + 1; its zero-based index wraps harmlessly in IDLE.
    logic [4:0] it_m1;
    assign it_m1 = cnt_q[4:0] + 5'(g);
`ifdef KUZ_CONST_ROM_EN
    assign cst[g] = c_rom[it_m1];
`else
    assign cst[g] = l_fn({120'd0, {3'b000, it_m1} + 8'd1});
`endif
    assign ch1[g+1] = l_fn(s_fn(ch1[g] ^ cst[g])) ^ ch0[g];
    assign ch0[g+1] = ch1[g];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    rk_d    = rk_q;
    done_d  = 1'b0;
    kv_d    = kv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a1_d    = key[255:128];
          a0_d    = key[127:0];
          rk_d[0] = key[255:128];
          rk_d[1] = key[127:0];
          kv_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a1_d  = ch1[RPC];
        a0_d  = ch0[RPC];
        cnt_d = cnt_q + 6'(RPC);
        for (int k = 1; k <= 4; k++) begin
          if (cnt_d == 6'(8 * k)) begin
            rk_d[2*k]   = ch1[RPC];
            rk_d[2*k+1] = ch0[RPC];
          end
        end
        if (cnt_d == 6'd32) begin
          state_d = StIdle;
          done_d  = 1'b1;
          kv_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      for (int i = 0; i < 10; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      done_q  <= done_d;
      kv_q    <= kv_d;
      for (int i = 0; i < 10; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign key_valid = kv_q;

  for (genvar g = 0; g < 10; g++) begin : g_all
    assign rk_all[128*g +: 128] = rk_q[g];
  end

  always_comb begin
    rk_out = '0;
    for (int i = 0; i < 10; i++) begin
      if (rk_idx == 4'(i)) rk_out = rk_q[i];
    end
  end

endmodule

// File: tb/tb_kuz_key_expand.sv
// Directed bench for kuz_key_expand: GOST reference key schedule, RPC=1 and RPC=4 instances.
module tb_kuz_key_expand;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start4;
  logic [255:0]  key;
  logic [3:0]    rk_idx, rk_idx4;
  logic          busy, done, key_valid;
  logic          busy4, done4, key_valid4;
  logic [127:0]  rk_out, rk_out4;
  logic [1279:0] rk_all, rk_all4;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] KEY_A =
    256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY_B =
    256'h0123456789abcdef0011223344556677ffeeddccbbaa99887766554433221100;

  logic [127:0] exp_k [10];

  always #5 clk = ~clk;

  kuz_key_expand #(.RPC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy), .done(done),
    .key_valid(key_valid), .rk_idx(rk_idx), .rk_out(rk_out), .rk_all(rk_all)
  );

  kuz_key_expand #(.RPC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .key(key), .busy(busy4), .done(done4),
    .key_valid(key_valid4), .rk_idx(rk_idx4), .rk_out(rk_out4), .rk_all(rk_all4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_keys(input string tag, input logic [1279:0] all);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s_K%0d", tag, i + 1), all[128*i +: 128], exp_k[i]);
  endtask

  // Accept on the next edge, then return the number of cycles until done (-1 on timeout).
  task automatic launch(input logic [255:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = done ? n : -1;
  endtask

  int lat;
  int last_done, npulse;
  logic prev_done4;

  initial begin
    exp_k[0] = 128'h8899aabbccddeeff0011223344556677;
    exp_k[1] = 128'hfedcba98765432100123456789abcdef;
    exp_k[2] = 128'hdb31485315694343228d6aef8cc78c44;
    exp_k[3] = 128'h3d4553d8e9cfec6815ebadc40a9ffd04;
    exp_k[4] = 128'h57646468c44a5e28d3e59246f429f1ac;
    exp_k[5] = 128'hbd079435165c6432b532e82834da581b;
    exp_k[6] = 128'h51e640757e8745de705727265a0098b1;
    exp_k[7] = 128'h5a7925017b9fdd3ed72a91a22286f984;
    exp_k[8] = 128'hbb44e25378c73123a5f32f73cdb6e517;
    exp_k[9] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

    rst_n = 1'b0; start = 1'b0; start4 = 1'b0; key = '0; rk_idx = '0; rk_idx4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_kv", 128'(key_valid), 128'd0);
    chk("rst_rk_all_nonzero", 128'(|rk_all), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference expansion at RPC=1.
    launch(KEY_A);
    chk("accept_busy", 128'(busy), 128'd1);
    chk("accept_kv", 128'(key_valid), 128'd0);
    wait_done(lat);
    chk("lat_rpc1", 128'(lat), 128'd32);
    chk("done_busy", 128'(busy), 128'd0);
    chk("done_kv", 128'(key_valid), 128'd1);
    chk_keys("run1", rk_all);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 128'(done), 128'd0);

    // Read-port sweep, including out-of-range indices.
    for (int i = 0; i < 16; i++) begin
      rk_idx = 4'(i);
      #1;
      chk($sformatf("rk_out_%0d", i), rk_out, (i < 10) ? exp_k[i] : 128'd0);
    end

    // Start pulsed mid-run with another key is ignored.
    launch(KEY_A);
    repeat (5) @(posedge clk);
    @(negedge clk);
    key = KEY_B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("lat_midstart", 128'(lat), 128'd26);
    chk_keys("midstart", rk_all);

    // Asynchronous reset at cycle 10 of a run, then a clean restart.
    launch(KEY_A);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_kv", 128'(key_valid), 128'd0);
    chk("abort_rk_all_nonzero", 128'(|rk_all), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(KEY_A);
    wait_done(lat);
    chk("lat_after_abort", 128'(lat), 128'd32);
    chk_keys("after_abort", rk_all);

    // RPC=4 with start held high: done every 9 cycles, key_valid drops on acceptance.
    @(negedge clk);
    key = KEY_A; start4 = 1'b1;
    last_done = -1; npulse = 0; prev_done4 = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (prev_done4) chk($sformatf("b2b_kv_drop_%0d", c), 128'(key_valid4), 128'd0);
      if (done4) begin
        npulse++;
        if (last_done < 0) chk("b2b_first_lat", 128'(c), 128'd9);
        else chk($sformatf("b2b_gap_%0d", c), 128'(c - last_done), 128'd9);
        last_done = c;
      end
      prev_done4 = done4;
    end
    @(negedge clk);
    start4 = 1'b0;
    chk("b2b_pulses", 128'(npulse), 128'd11);
    repeat (12) @(posedge clk);
    #1;
    chk("rpc4_kv", 128'(key_valid4), 128'd1);
    chk_keys("rpc4", rk_all4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kuz_key_expand.md
Name: kuz_key_expand

Overview:
Kuznyechik (GOST R 34.12-2015) key-schedule engine. It expands a 256-bit master key into the ten 128-bit round keys K1..K10 using the 32-iteration Feistel schedule with constants C_i = L(Vec128(i)). It is the parametrised successor of the fixed single-rate key calculator. Throughput is set by RPC (Feistel iterations per clock), with a start/busy/done handshake and an indexed round-key read port. It feeds the encrypt/decrypt round datapath.

Parameters:
RPC, 1, Feistel iterations per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
Derived NCYC = 32/RPC, run length in cycles.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request expansion; sampled only in IDLE
key  input  256  master key; key[255:128] is K1, key[127:0] is K2; sampled on the accepting edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when K1..K10 are complete
key_valid  output  1  level; all round keys valid
rk_idx  input  4  round-key select, 0..9 selects K1..K10
rk_out  output  128  combinational read of K[rk_idx+1]; 0 when rk_idx > 9
rk_all  output  1280  {K10,...,K1}; K1 occupies bits [127:0]

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; busy=0, done=0, key_valid=0.
  - All ten key registers, the a1/a0 working registers and the iteration counter are 0.
- IDLE and start=1 at edge E0:
  - Load a1=key[255:128], a0=key[127:0].
  - Write K1, K2 from the key.
  - Clear key_valid; busy=1; go to RUN; counter=0.
- Iteration i (1..32): (a1,a0) <- (L(S(a1 xor C_i)) xor a0, a1).
  - S: bytewise pi substitution.
  - L: 16 applications of R, GF(2^8) modulo x^8+x^7+x^6+x+1, coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
- RUN: each edge performs RPC chained iterations and counter += RPC.
  - When the counter reaches 8j (j=1..4), write K(2j+1)=a1, K(2j+2)=a0 on that same edge.
- Last RUN edge (E_NCYC): counter reaches 32, K9/K10 are written, done=1 for one cycle, busy=0, key_valid=1, go to IDLE.
- Latency: done rises at edge E0+NCYC (32, 16, 8, 4 cycles for RPC=1, 2, 4, 8).
- start while busy: ignored, with no effect on the run or on the key registers.
- start held high: a new run begins on the first IDLE edge. With start continuously high, runs therefore repeat back-to-back, one IDLE cycle apart. done and start acceptance never coincide.
- rst_n low mid-run: immediate abort; all registers return to reset values.
- key changes during RUN: no effect.
- rk_out / rk_all are pure reads of the key registers. Intermediate keys are visible during RUN, but only key_valid qualifies them.

Optional Feature:
Macro KUZ_CONST_ROM_EN.
- Defined: C_1..C_32 come from a 32x128 constant table indexed by iteration number, giving one L-transform per iteration in the critical path.
- Undefined: each C_i is computed on the fly as L(Vec128(i)), where Vec128(i) is i in the low byte with all other bytes 0. This costs an extra L-transform per iteration.
- Cycle behaviour and outputs are identical either way.

Test Plan:
- RPC=1, reset, then start with key=8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef -> done exactly 32 cycles after acceptance, with:
  - K1=8899aabbccddeeff0011223344556677, K2=fedcba98765432100123456789abcdef
  - K3=db31485315694343228d6aef8cc78c44, K4=3d4553d8e9cfec6815ebadc40a9ffd04
  - K5=57646468c44a5e28d3e59246f429f1ac, K6=bd079435165c6432b532e82834da581b
  - K7=51e640757e8745de705727265a0098b1, K8=5a7925017b9fdd3ed72a91a22286f984
  - K9=bb44e25378c73123a5f32f73cdb6e517, K10=72e9dd7416bcf45b755dbaa88e4a4043
- Repeat the same key with RPC=2, 4 and 8, each with and without KUZ_CONST_ROM_EN -> identical keys; done at 16, 8 and 4 cycles respectively.
- start pulsed mid-run with a different key -> ignored; final keys equal the first key's expansion.
- rst_n low at cycle 10 of an RPC=1 run -> busy=0, key_valid=0, rk_all=0 immediately. A fresh start then completes correctly in 32 cycles.
- After completion, sweep rk_idx 0..15 -> rk_out equals K1..K10 for 0..9, and 0 for 10..15.
- start held high for 100 cycles (RPC=4) -> done pulses every 9 cycles; key_valid drops on each acceptance edge.
